array_output_fifo_mp: RTL
=========================

Name: array_output_fifo_mp

Overview:
- Parametrised multi-write-port, single-read-port output FIFO between the systolic array output columns and the quantize/activate unit.
- Gathers up to NUM_WRITE_PORTS unquantized results per cycle and drains one per cycle to the consumer under a valid/ready handshake.
- Next generation of the array output buffer. Adds configurable depth and width, backpressure to the array, an optional same-cycle bypass, a flush, occupancy reporting and a sticky overflow error.

Parameters:
- MAX_N, 512, maximum matrix dimension.
- N_BITS, $clog2(MAX_N), row/col index width.
- DATA_W, 32, width of the unquantized result.
- NUM_WRITE_PORTS, 4, parallel write ports, 1..8.
- DEPTH, 8, entries. Must be a power of two and >= NUM_WRITE_PORTS.
- BYPASS_EN, 1, enables the empty-FIFO same-cycle bypass.
- PTR_BITS, $clog2(DEPTH), pointer width.
- CNT_BITS, $clog2(DEPTH+1), occupancy width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of contents; does not clear err_overflow.
- in_valid  in  [NUM_WRITE_PORTS] x 1  per-port write request.
- in_data  in  [NUM_WRITE_PORTS] x DATA_W  result value.
- in_row  in  [NUM_WRITE_PORTS] x N_BITS  result row.
- in_col  in  [NUM_WRITE_PORTS] x N_BITS  result column.
- in_ready  out  1  FIFO can absorb a full write group this cycle.
- out_valid  out  1  output entry valid.
- out_data  out  DATA_W  output value.
- out_row  out  N_BITS  output row.
- out_col  out  N_BITS  output column.
- out_ready  in  1  consumer accepts the output this cycle.
- count  out  CNT_BITS  current occupancy (registered).
- idle  out  1  count==0 and no in_valid asserted.
- err_overflow  out  1  sticky: a write group was dropped.
- clr_err  in  1  clears err_overflow.

Behaviour:
- Reset:
  - count=0, rd_ptr=wr_ptr=0, all entry valid bits=0, err_overflow=0.
  - Outputs after reset: out_valid=0, in_ready=1, idle=1 when no in_valid.
- in_ready = (DEPTH - count) >= NUM_WRITE_PORTS.
  - Registered-count based only. It does not credit a same-cycle pop, so there is no combinational path from out_ready to in_ready.
- Write group:
  - Accepted only when in_ready=1; all-or-nothing.
  - If any in_valid=1 while in_ready=0, every port is dropped that cycle and err_overflow sets next cycle.
- Compaction:
  - Accepted valid ports are written in ascending port order to consecutive slots starting at wr_ptr. Gaps between valid ports are skipped.
  - wr_ptr advances by the number written, modulo DEPTH.
- Bypass (BYPASS_EN=1 and count==0 and out_ready=1 and in_ready=1 and any in_valid):
  - The lowest-index valid port drives out_* combinationally with out_valid=1. It is consumed that cycle and never stored.
  - The remaining valid ports are written, compacted.
- Normal output (no bypass):
  - out_valid = entry[rd_ptr].valid; out_* = entry[rd_ptr] fields.
  - A pop occurs when out_valid & out_ready: entry cleared, rd_ptr advances modulo DEPTH.
- Bypass disabled (BYPASS_EN=0): minimum write-to-out_valid latency is 1 cycle. With bypass it is 0 cycles when the FIFO is empty.
- Data fields (out_data/out_row/out_col) are don't-care when out_valid=0. Simulation must not propagate X into out_valid.
- count_next = count + writes_stored - pop. It is always within 0..DEPTH by construction. An assertion flags any violation.
- Same-cycle write and pop are both applied. A pop of a full FIFO plus a write is impossible because in_ready is already 0 at count > DEPTH-NUM_WRITE_PORTS.
- flush:
  - Priority over write, pop and bypass. Next cycle count=0, pointers=0, all valid bits=0.
  - Inputs presented in the flush cycle are discarded without setting err_overflow.
  - out_valid is forced to 0 during the flush cycle.
- err_overflow:
  - Set has priority over clr_err in the same cycle.
  - Cleared only by reset or clr_err.
- Reset mid-operation discards all contents; the next cycle is identical to post-reset.
- idle is combinational: (count==0) && !(|in_valid).

Test Plan:
- Reset, then drive in_valid=4'b1111 with data 10,11,12,13 at row 0, col 0..3, out_ready=0 -> count=4 next cycle, in_ready=1 (DEPTH=8). A second group -> count=8, in_ready=0.
- Empty FIFO, BYPASS_EN=1, out_ready=1, in_valid=4'b1010 with data A (port1) and B (port3) -> out_valid=1, out_data=A in the same cycle. Next cycle count=1 and out_data=B.
- count=8, in_valid=4'b0001, out_ready=1 -> port dropped, err_overflow=1 next cycle, count=7. err_overflow holds until clr_err=1.
- Wrap-around: push 3 groups of 4 while draining 1 per cycle (DEPTH=8) -> output sequence matches port-order compaction across the pointer wrap, and no entry is lost or duplicated.
- count=5 with flush=1 and in_valid=4'b1111 in the same cycle -> count=0, out_valid=0, err_overflow unchanged.
- Instance with BYPASS_EN=0: empty FIFO, out_ready=1, in_valid=4'b0001 -> out_valid=0 in that cycle, out_valid=1 the next cycle, then popped; idle=1 the following cycle.

Source files
------------

// File: rtl/array_output_fifo_mp.sv
// Multi-write-port, single-read-port output FIFO between the array columns
// and the quantize/activate unit; compacts each write group, optional bypass.
module array_output_fifo_mp #(
    parameter int MAX_N           = 512,
    parameter int N_BITS          = $clog2(MAX_N),
    parameter int DATA_W          = 32,
    parameter int NUM_WRITE_PORTS = 4,
    parameter int DEPTH           = 8,
    parameter int BYPASS_EN       = 1,
    parameter int PTR_BITS        = $clog2(DEPTH),
    parameter int CNT_BITS        = $clog2(DEPTH + 1)
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         flush,
    input  logic [NUM_WRITE_PORTS-1:0]                   in_valid,
    input  logic [NUM_WRITE_PORTS-1:0][DATA_W-1:0]       in_data,
    input  logic [NUM_WRITE_PORTS-1:0][N_BITS-1:0]       in_row,
    input  logic [NUM_WRITE_PORTS-1:0][N_BITS-1:0]       in_col,
    output logic                                         in_ready,
    output logic                                         out_valid,
    output logic [DATA_W-1:0]                            out_data,
    output logic [N_BITS-1:0]                            out_row,
    output logic [N_BITS-1:0]                            out_col,
    input  logic                                         out_ready,
    output logic [CNT_BITS-1:0]                          count,
    output logic                                         idle,
    output logic                                         err_overflow,
    input  logic                                         clr_err
);

    localparam int IDX_W = (NUM_WRITE_PORTS > 1) ? $clog2(NUM_WRITE_PORTS) : 1;
    localparam logic [CNT_BITS-1:0] ROOM_MAX = CNT_BITS'(DEPTH - NUM_WRITE_PORTS);
    localparam logic [CNT_BITS:0] DEPTH_X = (CNT_BITS + 1)'(DEPTH);

    logic [DATA_W-1:0]   data_q [DEPTH];
    logic [N_BITS-1:0]   row_q  [DEPTH];
    logic [N_BITS-1:0]   col_q  [DEPTH];
    logic [DEPTH-1:0]    vld_q;
    logic [PTR_BITS-1:0] rd_ptr_q;
    logic [PTR_BITS-1:0] wr_ptr_q;
    logic [CNT_BITS-1:0] count_q;
    logic [CNT_BITS-1:0] count_d;
    logic                err_q;
    logic                err_d;

    logic                       any_v;
    logic                       accept;
    logic                       bypass;
    logic                       pop;
    logic [IDX_W-1:0]           low;
    logic [NUM_WRITE_PORTS-1:0] wmask;
    logic [PTR_BITS-1:0]        slot [NUM_WRITE_PORTS];
    logic [CNT_BITS-1:0]        nwr;
    logic [CNT_BITS:0]          count_x;

    always_comb begin
        any_v    = |in_valid;
        in_ready = (count_q <= ROOM_MAX);
        accept   = in_ready && !flush;
        low      = '0;
        for (int p = NUM_WRITE_PORTS - 1; p >= 0; p--) begin
            if (in_valid[p]) low = IDX_W'(p);
        end
        bypass = (BYPASS_EN != 0) && accept && any_v && out_ready
                 && (count_q == '0);
        // Ports are packed into consecutive slots; the bypassed port is skipped.
        nwr   = '0;
        wmask = '0;
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
            slot[p] = wr_ptr_q + PTR_BITS'(nwr);
            if (in_valid[p] && accept && !(bypass && (low == IDX_W'(p)))) begin
                wmask[p] = 1'b1;
                nwr      = nwr + CNT_BITS'(1);
            end
        end
        pop       = !flush && !bypass && vld_q[rd_ptr_q] && out_ready;
        out_valid = !flush && (bypass || vld_q[rd_ptr_q]);
        out_data  = bypass ? in_data[low] : data_q[rd_ptr_q];
        out_row   = bypass ? in_row[low]  : row_q[rd_ptr_q];
        out_col   = bypass ? in_col[low]  : col_q[rd_ptr_q];
        count_x   = {1'b0, count_q} + {1'b0, nwr} - (CNT_BITS + 1)'(pop);
        count_d   = count_x[CNT_BITS-1:0];
        err_d     = (!flush && any_v && !in_ready) || (err_q && !clr_err);
        idle      = (count_q == '0) && !any_v;
    end

    assign count        = count_q;
    assign err_overflow = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
            err_q    <= 1'b0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
            err_q    <= err_d;
        end else begin
            assert (count_x <= DEPTH_X);
            if (pop) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= rd_ptr_q + PTR_BITS'(1);
            end
            for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                if (wmask[p]) vld_q[slot[p]] <= 1'b1;
            end
            wr_ptr_q <= wr_ptr_q + PTR_BITS'(nwr);
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
            if (wmask[p]) begin
                data_q[slot[p]] <= in_data[p];
                row_q[slot[p]]  <= in_row[p];
                col_q[slot[p]]  <= in_col[p];
            end
        end
    end

endmodule
